// File: rtl/fb_pkg.sv
// Shared constants and encodings for the frame-buffer write arbiter.
// The clear engine is built only when FB_WR_CLEAR_EN is defined.
package fb_pkg;

  localparam int unsigned FB_W     = 320;
  localparam int unsigned FB_H     = 240;
  localparam int unsigned FB_DEPTH = 76800;
  localparam int unsigned FB_AW    = 17;
  localparam int unsigned FB_DW    = 12;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CAM  = 2'd1,
    SRC_CLR  = 2'd2,
    SRC_GFX  = 2'd3
  } src_e;

endpackage

// File: rtl/fb_wr_arbiter_if.sv
// Source-side and BRAM-side signals of the frame-buffer write arbiter.
// clear_* members are only meaningful when FB_WR_CLEAR_EN is defined.
interface fb_wr_if import fb_pkg::*; #(
  parameter int unsigned AW = FB_AW,
  parameter int unsigned DW = FB_DW
);

  logic          cam_valid;
  logic [AW-1:0] cam_addr;
  logic [DW-1:0] cam_data;
  logic          gfx_valid;
  logic          gfx_ready;
  logic [AW-1:0] gfx_addr;
  logic [DW-1:0] gfx_data;
  logic          clear_start;
  logic [DW-1:0] clear_color;
  logic          clear_busy;
  logic          clear_done;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [15:0]   oob_cnt;

  modport master (
    output cam_valid, cam_addr, cam_data,
    output gfx_valid, gfx_addr, gfx_data,
    output clear_start, clear_color,
    input  gfx_ready, clear_busy, clear_done,
    input  wea, addra, dina, oob_cnt
  );

  modport slave (
    input  cam_valid, cam_addr, cam_data,
    input  gfx_valid, gfx_addr, gfx_data,
    input  clear_start, clear_color,
    output gfx_ready, clear_busy, clear_done,
    output wea, addra, dina, oob_cnt
  );

endinterface

// File: rtl/fb_clear_gen.sv
// Full-buffer fill engine: clear address counter, colour latch, stall and last-write flag.
// Instantiated by fb_wr_arbiter only when FB_WR_CLEAR_EN is defined.
module fb_clear_gen import fb_pkg::*; #(
  parameter int unsigned DEPTH = FB_DEPTH,
  parameter int unsigned AW    = FB_AW,
  parameter int unsigned DW    = FB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] color,
  input  logic          stall,
  output logic          busy,
  output logic          req_c,
  output logic          last_c,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] fill
);

  state_e        state, state_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] fill_n;

  // State, address and colour registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
      fill  <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      fill  <= fill_n;
    end
  end

  // Next state: the counter is compared against the last pixel, never wrapped by width
  always_comb begin
    state_n = state;
    addr_n  = addr;
    fill_n  = fill;
    req_c   = 1'b0;
    last_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_CLEAR;
          addr_n  = '0;
          fill_n  = color;
        end
      end
      ST_CLEAR: begin
        if (!stall) begin
          req_c = 1'b1;
          if (addr == AW'(DEPTH - 1)) begin
            last_c  = 1'b1;
            state_n = ST_IDLE;
            addr_n  = '0;
          end else begin
            addr_n = addr + AW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CLEAR);

endmodule

// File: rtl/fb_wr_arbiter.sv
// Owner of the frame-buffer BRAM write port: camera > clear engine > graphics.
// Define FB_WR_CLEAR_EN to build the clear engine; otherwise priority is camera > graphics.
module fb_wr_arbiter #(
  parameter int unsigned FB_DEPTH = fb_pkg::FB_DEPTH,
  parameter int unsigned AW       = fb_pkg::FB_AW,
  parameter int unsigned DW       = fb_pkg::FB_DW
) (
  input logic   clk,
  input logic   rst,
  fb_wr_if.slave bus
);
  import fb_pkg::*;

  logic          clr_busy;
  logic          clr_req_c;
  logic          clr_last_c;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] clr_fill;

  logic          gfx_ready_c;
  src_e          src_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_data_c;
  logic          oob_c;

  logic          wea_q;
  logic [AW-1:0] addra_q;
  logic [DW-1:0] dina_q;
  logic          done_q;
  logic [15:0]   oob_q;

`ifdef FB_WR_CLEAR_EN
  fb_clear_gen #(
    .DEPTH (FB_DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_clear (
    .clk    (clk),
    .rst    (rst),
    .start  (bus.clear_start),
    .color  (bus.clear_color),
    .stall  (bus.cam_valid),
    .busy   (clr_busy),
    .req_c  (clr_req_c),
    .last_c (clr_last_c),
    .addr   (clr_addr),
    .fill   (clr_fill)
  );
`else
  logic unused_c;
  assign unused_c   = ^{bus.clear_start, bus.clear_color};
  assign clr_busy   = 1'b0;
  assign clr_req_c  = 1'b0;
  assign clr_last_c = 1'b0;
  assign clr_addr   = '0;
  assign clr_fill   = '0;
`endif

  // Graphics is only accepted when neither the camera nor the clear engine owns the port
  assign gfx_ready_c = !rst && !clr_busy && !bus.cam_valid;

  // Fixed-priority source select
  always_comb begin
    src_c      = SRC_NONE;
    sel_addr_c = '0;
    sel_data_c = '0;
    if (bus.cam_valid) begin
      src_c      = SRC_CAM;
      sel_addr_c = bus.cam_addr;
      sel_data_c = bus.cam_data;
    end else if (clr_req_c) begin
      src_c      = SRC_CLR;
      sel_addr_c = clr_addr;
      sel_data_c = clr_fill;
    end else if (bus.gfx_valid && gfx_ready_c) begin
      src_c      = SRC_GFX;
      sel_addr_c = bus.gfx_addr;
      sel_data_c = bus.gfx_data;
    end
  end

  assign oob_c = (src_c != SRC_NONE) && (sel_addr_c >= AW'(FB_DEPTH));

  // Registered write port; address/data hold when nothing legal is written
  always_ff @(posedge clk) begin
    if (rst) begin
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      done_q  <= 1'b0;
      oob_q   <= '0;
    end else begin
      wea_q  <= (src_c != SRC_NONE) && !oob_c;
      done_q <= (src_c == SRC_CLR) && clr_last_c;
      if ((src_c != SRC_NONE) && !oob_c) begin
        addra_q <= sel_addr_c;
        dina_q  <= sel_data_c;
      end
      if (oob_c && (oob_q != 16'hFFFF)) begin
        oob_q <= oob_q + 16'd1;
      end
    end
  end

  assign bus.gfx_ready  = gfx_ready_c;
  assign bus.clear_busy = clr_busy;
  assign bus.clear_done = done_q;
  assign bus.wea        = wea_q;
  assign bus.addra      = addra_q;
  assign bus.dina       = dina_q;
  assign bus.oob_cnt    = oob_q;

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Testbench for fb_wr_arbiter; clear-engine scenarios run when FB_WR_CLEAR_EN is defined.
module tb_fb_wr_arbiter;
  import fb_pkg::*;

  localparam int DEPTH = int'(FB_DEPTH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_wr_if bus ();
  fb_wr_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // reference model state
  bit m_clr;
  int m_ptr, m_col, m_oob, m_addr, m_data;
  bit m_wea, m_done, m_chk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit cv, input int ca, input int cd,
                       input bit gv, input int ga, input int gd, input bit st, input int col);
    rst             = r;
    bus.cam_valid   = cv;
    bus.cam_addr    = FB_AW'(ca);
    bus.cam_data    = FB_DW'(cd);
    bus.gfx_valid   = gv;
    bus.gfx_addr    = FB_AW'(ga);
    bus.gfx_data    = FB_DW'(gd);
    bus.clear_start = st;
    bus.clear_color = FB_DW'(col);
  endtask

  // One clock cycle: drive, check ready, advance model, check registered outputs
  task automatic cycle(input bit r, input bit cv, input int ca, input int cd,
                       input bit gv, input int ga, input int gd, input bit st, input int col);
    bit was, rdy, win;
    int wa, wd;
    drive(r, cv, ca, cd, gv, ga, gd, st, col);
    #1;
    rdy = !r && !m_clr && !cv;
    check("gfx_ready", bus.gfx_ready, rdy);
    if (r) begin
      m_clr = 0; m_ptr = 0; m_oob = 0; m_wea = 0; m_addr = 0; m_data = 0;
      m_done = 0; m_chk = 1;
    end else begin
      was = m_clr; win = 0; wa = 0; wd = 0; m_done = 0;
      if (cv) begin
        win = 1; wa = ca; wd = cd;
      end else if (was) begin
        win = 1; wa = m_ptr; wd = m_col;
        if (m_ptr == DEPTH - 1) begin
          m_clr = 0; m_done = 1; m_ptr = 0;
        end else begin
          m_ptr++;
        end
      end else if (gv && rdy) begin
        win = 1; wa = ga; wd = gd;
      end
`ifdef FB_WR_CLEAR_EN
      if (!was && st) begin
        m_clr = 1; m_ptr = 0; m_col = col;
      end
`endif
      m_wea = win && (wa < DEPTH);
      m_chk = !(win && wa >= DEPTH);
      if (win && wa >= DEPTH && m_oob < 65535) m_oob++;
      if (m_wea) begin
        m_addr = wa; m_data = wd;
      end
    end
    @(posedge clk);
    #1;
    check("wea", bus.wea, m_wea);
    check("clear_busy", bus.clear_busy, m_clr);
    check("clear_done", bus.clear_done, m_done);
    check("oob_cnt", bus.oob_cnt, m_oob);
    if (m_chk) begin
      check("addra", bus.addra, m_addr);
      check("dina", bus.dina, m_data);
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit cv; int ca; int cd;
    bit gv; int ga; int gd;
    bit rdy; bit wea; int addr; int data; bit chk; int oob;
  } vec_t;

  vec_t tv[8];

  initial begin
    int next_fill, fill_bad, done_cnt, busy_cyc, injected, ca, cv;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // reset: outputs cleared, graphics held off while rst is high
    cycle(1, 0, 0, 0, 1, 3, 3, 0, 0);
    cycle(1, 0, 0, 0, 1, 3, 3, 0, 0);

    // directed vectors from a freshly reset state
    tv[0] = '{1, 100,    'hABC, 0, 0,     0,     0, 1, 100,   'hABC, 1, 0};
    tv[1] = '{1, 7,      'h111, 1, 5,     'h0F0, 0, 1, 7,     'h111, 1, 0};
    tv[2] = '{0, 0,      0,     1, 5,     'h0F0, 1, 1, 5,     'h0F0, 1, 0};
    tv[3] = '{0, 0,      0,     0, 0,     0,     1, 0, 5,     'h0F0, 1, 0};
    tv[4] = '{0, 0,      0,     1, 76800, 'h555, 1, 0, 0,     0,     0, 1};
    tv[5] = '{1, 131071, 'h777, 0, 0,     0,     0, 0, 0,     0,     0, 2};
    tv[6] = '{0, 0,      0,     0, 0,     0,     1, 0, 0,     0,     0, 2};
    tv[7] = '{0, 0,      0,     1, 76799, 'hFFF, 1, 1, 76799, 'hFFF, 1, 2};
    for (int i = 0; i < 8; i++) begin
      drive(0, tv[i].cv, tv[i].ca, tv[i].cd, tv[i].gv, tv[i].ga, tv[i].gd, 0, 0);
      #1;
      check($sformatf("vec%0d_ready", i), bus.gfx_ready, tv[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_wea", i), bus.wea, tv[i].wea);
      check($sformatf("vec%0d_oob", i), bus.oob_cnt, tv[i].oob);
      if (tv[i].chk) begin
        check($sformatf("vec%0d_addra", i), bus.addra, tv[i].addr);
        check($sformatf("vec%0d_dina", i), bus.dina, tv[i].data);
      end
    end

    // randomized camera/graphics traffic against the model
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      int ga;
      ca = ($urandom_range(0, 7) == 0) ? DEPTH + int'($urandom_range(0, 54271)) : int'($urandom_range(0, DEPTH - 1));
      ga = ($urandom_range(0, 7) == 0) ? DEPTH + int'($urandom_range(0, 54271)) : int'($urandom_range(0, DEPTH - 1));
      cycle(0, ($urandom_range(0, 3) == 0), ca, int'($urandom_range(0, 4095)),
            $urandom_range(0, 1) == 1, ga, int'($urandom_range(0, 4095)),
`ifdef FB_WR_CLEAR_EN
            0,
`else
            ($urandom_range(0, 9) == 0),
`endif
            int'($urandom_range(0, 4095)));
    end

`ifdef FB_WR_CLEAR_EN
    // full clear with a 10-pixel camera burst when the fill reaches address 500
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 'h123);
    next_fill = 0; fill_bad = 0; done_cnt = 0; busy_cyc = 0; injected = 0;
    for (int n = 0; n < 80000 && bus.clear_busy; n++) begin
      busy_cyc++;
      cv = (m_ptr == 500 && injected < 10) ? 1 : 0;
      if (cv != 0) injected++;
      cycle(0, cv != 0, 2000 + injected, 'hABC,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 1000)), 'h3C3,
            n == 1000, 'h456);
      if (bus.wea && bus.dina == 12'h123) begin
        if (int'(bus.addra) == next_fill) next_fill++;
        else fill_bad++;
      end
      if (bus.clear_done) begin
        done_cnt++;
        check("done_with_last_addr", bus.addra, DEPTH - 1);
        check("done_with_last_wea", bus.wea, 1);
      end
    end
    check("clear_finished", bus.clear_busy, 0);
    check("fill_writes", next_fill, DEPTH);
    check("fill_out_of_order", fill_bad, 0);
    check("done_pulses", done_cnt, 1);
    check("busy_cycles", busy_cyc, DEPTH + 10);
    check("cam_injected", injected, 10);
    idle();

    // reset mid-clear aborts without clear_done; a new clear restarts at 0
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 'h222);
    for (int n = 0; n < 4000 && m_ptr != 3000; n++) idle();
    check("reached_3000", m_ptr, 3000);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 'h333);
    idle();
    check("restart_addr", bus.addra, 0);
    check("restart_data", bus.dina, 'h333);
    idle();
    check("restart_next_addr", bus.addra, 1);
`else
    // clear_start is inert without the clear engine
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 'h123);
    cycle(0, 0, 0, 0, 1, 9, 'h0AA, 0, 0);
    check("no_clear_busy", bus.clear_busy, 0);
    check("gfx_after_start", bus.addra, 9);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
